instr_loader: RTL and testbench

Sequential writer that fills the processor's instruction memory from a byte stream (host UART/debug link) before program execution. It frames a length-prefixed stream, assembles big-endian 32-bit instruction words, and issues one write per word at consecutive word addresses. It also checks an XOR checksum and reports done or error. It is the producer side of the instruction memory that the fetch/decode path, including immediate extension, later reads.

---
 rtl/instr_loader.sv | 138 +++++++++++++
 tb/tb_instr_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction-memory loader: frames a length-prefixed byte stream, assembles
// big-endian 32-bit words, writes them to consecutive addresses and verifies an XOR checksum.
module instr_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       n_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    csum_d     = csum_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    count_d    = count_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    n_full     = {len_q[15:8], byte_in};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          count_d = '0;
          addr_d  = '0;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d[15:8] = byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d = n_full;
          if ({1'b0, n_full} > CAPACITY) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d = {word_q[23:0], byte_in};
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Address wraps to 0 after a full-memory load; no further write follows.
        mem_we  = 1'b1;
        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        count_d = count_q + 16'd1;
        if (count_q + 16'd1 == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (ADDR_W=4): good/bad checksum, empty load,
// length overflow and full-memory load, stalled stream, and reset mid-load.
module tb_instr_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   word_count;

  int errors = 0;
  int checks = 0;
  int collisions = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [7:0]    csum_m;

  instr_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Log every write; a write cycle must never also accept a byte.
  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (byte_ready) collisions <= collisions + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    while (gap > 0 && $urandom_range(99) < gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $error("FAIL byte_ready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31-8*i -: 8];
      csum_m ^= b;
      send_byte(b, gap);
    end
    exp_addr.push_back(AW'(exp_addr.size()));
    exp_data.push_back(w);
  endtask

  task automatic send_len(input logic [15:0] n, input int gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  task automatic do_start();
    wr_addr.delete();
    wr_data.delete();
    exp_addr.delete();
    exp_data.delete();
    csum_m = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
        check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input int wc);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(wc));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // N=2, correct checksum; a start pulse mid-load must be ignored
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
    send_len(16'd2, 0);
    send_word(32'h12345678, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", 32'(busy), 32'd1);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h2A, 0);
    check_end("n2_good", 1'b1, 1'b0, 2);
    check_writes("n2_good");

    // Same stream, corrupted checksum
    do_start();
    send_len(16'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h2B, 0);
    check_end("n2_bad", 1'b0, 1'b1, 2);
    check_writes("n2_bad");

    // Empty loads
    do_start();
    send_len(16'd0, 0);
    send_byte(8'h00, 0);
    check_end("n0_good", 1'b1, 1'b0, 0);
    check_writes("n0_good");
    do_start();
    send_len(16'd0, 0);
    send_byte(8'h5A, 0);
    check_end("n0_bad", 1'b0, 1'b1, 0);
    check_writes("n0_bad");

    // Length overflow: 17 words into a 16-word memory
    do_start();
    send_len(16'd17, 0);
    check_end("n17", 1'b0, 1'b1, 0);
    check_writes("n17");

    // Full-memory load; address wraps back to 0
    do_start();
    send_len(16'd16, 0);
    for (int i = 0; i < 16; i++) send_word({8'(i), 8'hA5, 8'h3C, 8'h00}, 0);
    send_byte(csum_m, 0);
    check_end("n16", 1'b1, 1'b0, 16);
    check("n16_addr_wrap", 32'(mem_addr), 32'd0);
    check_writes("n16");

    // Stalled stream with ~50% valid duty
    do_start();
    send_len(16'd3, 50);
    send_word(32'hCAFEF00D, 50);
    send_word(32'h0BADC0DE, 50);
    send_word(32'h89ABCDEF, 50);
    send_byte(csum_m, 50);
    check_end("gaps", 1'b1, 1'b0, 3);
    check_writes("gaps");
    check("gaps_write_accept", 32'(collisions), 32'd0);

    // Reset after 6 payload bytes
    do_start();
    send_len(16'd2, 0);
    send_word(32'h12345678, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("midrst_idle");
    check_writes("midrst");

    do_start();
    send_len(16'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h2A, 0);
    check_end("reload", 1'b1, 1'b0, 2);
    check_writes("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
